// File: rtl/bcd_operand_loader.sv
// bcd_operand_loader: accumulates MSD-first BCD digits into binary X/Y operands
// and hands the pair to the MDR core through a valid/ack handshake.
module bcd_operand_loader #(
  parameter int W_DATA     = 16,
  parameter int W_BCD      = 4,
  parameter int MAX_DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic [W_BCD-1:0]  digit_i,
  input  logic              digit_valid_i,
  output logic              digit_ready_o,
  input  logic              enter_i,
  output logic [W_DATA-1:0] op_x_o,
  output logic [W_DATA-1:0] op_y_o,
  output logic              operands_valid_o,
  input  logic              operands_ack_i,
  output logic              stage_o,
  output logic [2:0]        digit_count_o,
  output logic              overflow_o,
  output logic              bad_digit_o
);
  typedef enum logic [1:0] {LOAD_X, LOAD_Y, HOLD} state_t;
  state_t state;
  logic [W_DATA-1:0] acc, acc_cur;
  logic [W_DATA+3:0] acc_next;
  logic take, bad, full, big, legal;
  assign digit_ready_o = state != HOLD;
  assign take = digit_valid_i && digit_ready_o;
  // acc*10 + digit, widened by 4 bits so the range check sees the carry
  assign acc_next = ({4'b0, acc} << 3) + ({4'b0, acc} << 1)
                  + {{(W_DATA + 4 - W_BCD){1'b0}}, digit_i};
  assign bad = digit_i > W_BCD'(9);
  assign full = digit_count_o >= 3'(MAX_DIGITS);
  assign big = acc_next > {4'b0, {W_DATA{1'b1}}};
  assign legal = take && !bad && !full && !big;
  assign acc_cur = legal ? acc_next[W_DATA-1:0] : acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_X;
      acc <= '0;
      digit_count_o <= '0;
      op_x_o <= '0;
      op_y_o <= '0;
      operands_valid_o <= 1'b0;
      stage_o <= 1'b0;
      overflow_o <= 1'b0;
      bad_digit_o <= 1'b0;
    end else if (clear_i) begin
      state <= LOAD_X;
      acc <= '0;
      digit_count_o <= '0;
      op_x_o <= '0;
      op_y_o <= '0;
      operands_valid_o <= 1'b0;
      stage_o <= 1'b0;
      overflow_o <= 1'b0;
      bad_digit_o <= 1'b0;
    end else begin
      bad_digit_o <= take && bad;
      if (take && !bad && (full || big)) overflow_o <= 1'b1;
      if (legal) begin
        acc <= acc_next[W_DATA-1:0];
        digit_count_o <= digit_count_o + 3'd1;
      end
      // a commit sees this cycle's digit first, then zeroes the accumulator
      case (state)
        LOAD_X: if (enter_i) begin
          op_x_o <= acc_cur;
          acc <= '0;
          digit_count_o <= '0;
          stage_o <= 1'b1;
          state <= LOAD_Y;
        end
        LOAD_Y: if (enter_i) begin
          op_y_o <= acc_cur;
          acc <= '0;
          digit_count_o <= '0;
          operands_valid_o <= 1'b1;
          state <= HOLD;
        end
        default: if (operands_ack_i) begin
          operands_valid_o <= 1'b0;
          overflow_o <= 1'b0;
          stage_o <= 1'b0;
          state <= LOAD_X;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_operand_loader.sv
// tb_bcd_operand_loader: directed test-plan sequences plus random digit traffic
// against an integer-arithmetic model of the operand loader.
module tb_bcd_operand_loader;
  logic clk = 0, rst_n = 0, clear_i = 0, digit_valid_i = 0, enter_i = 0, operands_ack_i = 0;
  logic [3:0] digit_i = 0;
  logic digit_ready_o, operands_valid_o, stage_o, overflow_o, bad_digit_o;
  logic [15:0] op_x_o, op_y_o;
  logic [2:0] digit_count_o;
  int n_cmp = 0, n_err = 0;
  int m_phase, m_val, m_cnt, m_x, m_y, m_valid, m_ovf, m_bad;

  bcd_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .digit_i(digit_i),
    .digit_valid_i(digit_valid_i), .digit_ready_o(digit_ready_o), .enter_i(enter_i),
    .op_x_o(op_x_o), .op_y_o(op_y_o), .operands_valid_o(operands_valid_o),
    .operands_ack_i(operands_ack_i), .stage_o(stage_o), .digit_count_o(digit_count_o),
    .overflow_o(overflow_o), .bad_digit_o(bad_digit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_val = 0; m_cnt = 0; m_x = 0; m_y = 0; m_valid = 0; m_ovf = 0; m_bad = 0;
  endtask

  task automatic check_all();
    chk("ready", digit_ready_o, m_phase != 2);
    chk("stage", stage_o, m_phase != 0);
    chk("op_x", op_x_o, m_x);
    chk("op_y", op_y_o, m_y);
    chk("valid", operands_valid_o, m_valid);
    chk("count", digit_count_o, m_cnt);
    chk("ovf", overflow_o, m_ovf);
    chk("bad", bad_digit_o, m_bad);
  endtask

  task automatic step(input bit dv, input int d, input bit en, input bit ack, input bit clr);
    bit rdy;
    digit_valid_i = dv; digit_i = 4'(d); enter_i = en; operands_ack_i = ack; clear_i = clr;
    @(posedge clk); #1;
    if (clr) m_reset();
    else begin
      rdy = m_phase != 2;
      m_bad = 0;
      if (dv && rdy) begin
        if (d > 9) m_bad = 1;
        else if (m_cnt >= 5 || m_val * 10 + d > 65535) m_ovf = 1;
        else begin m_val = m_val * 10 + d; m_cnt++; end
      end
      if (en && m_phase == 0) begin m_x = m_val; m_val = 0; m_cnt = 0; m_phase = 1; end
      else if (en && m_phase == 1) begin m_y = m_val; m_val = 0; m_cnt = 0; m_phase = 2; m_valid = 1; end
      else if (m_phase == 2 && ack) begin m_phase = 0; m_valid = 0; m_ovf = 0; end
    end
    digit_valid_i = 0; enter_i = 0; operands_ack_i = 0; clear_i = 0;
    check_all();
  endtask

  task automatic digits(input int n, input int v);
    for (int i = n - 1; i >= 0; i--) step(1, (v / (10 ** i)) % 10, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    #3 check_all();
    #9 rst_n = 1;
    // basic load
    digits(3, 123); step(0, 0, 1, 0, 0);
    chk("x_123", op_x_o, 16'h007B);
    digits(2, 45); step(0, 0, 1, 0, 0);
    chk("y_45", op_y_o, 16'h002D);
    chk("valid_rise", operands_valid_o, 1);
    for (int i = 0; i < 10; i++) step(1, 3, 1, 0, 0);
    chk("hold_valid", operands_valid_o, 1);
    step(0, 0, 0, 1, 0);
    chk("ack_valid", operands_valid_o, 0);
    chk("ack_stage", stage_o, 0);
    // range limits
    digits(5, 65535);
    chk("max_ovf", overflow_o, 0);
    step(0, 0, 1, 0, 0);
    chk("x_ffff", op_x_o, 16'hFFFF);
    digits(5, 65536);
    chk("ovf_rise", overflow_o, 1);
    step(0, 0, 1, 0, 0);
    chk("y_6553", op_y_o, 16'h1999);
    step(0, 0, 0, 1, 0);
    chk("ovf_ack", overflow_o, 0);
    // digit count limit
    digits(5, 0); step(1, 7, 0, 0, 0);
    chk("cnt_ovf", overflow_o, 1);
    chk("cnt_sat", digit_count_o, 5);
    step(0, 0, 1, 0, 0);
    chk("x_zero", op_x_o, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("ovf_clr", overflow_o, 0);
    // bad digit and same-cycle commit
    step(1, 1, 0, 0, 0);
    step(1, 10, 0, 0, 0);
    chk("bad_pulse", bad_digit_o, 1);
    chk("bad_cnt", digit_count_o, 1);
    step(0, 0, 0, 0, 0);
    chk("bad_end", bad_digit_o, 0);
    step(0, 0, 0, 0, 1);
    step(1, 4, 0, 0, 0); step(1, 2, 1, 0, 0);
    chk("x_42", op_x_o, 42);
    // clear mid LOAD_Y
    step(1, 7, 0, 0, 0); step(1, 8, 0, 0, 1);
    chk("clr_x", op_x_o, 0);
    chk("clr_stage", stage_o, 0);
    // async reset in HOLD
    digits(1, 9); step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
    chk("hold_pre", operands_valid_o, 1);
    #2 rst_n = 0; #1;
    m_reset();
    chk("arst_valid", operands_valid_o, 0);
    check_all();
    #3 rst_n = 1;
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 6, ($urandom_range(0, 19) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_operand_loader.md
# bcd_operand_loader

Input-side front end of the MDR datapath. It accepts decimal operands one BCD digit at a time, for example from keypad or switch debouncing logic, and accumulates each operand into a 16-bit unsigned binary value. It delivers the X/Y operand pair to the MDR core through a valid/ack handshake. It is the reverse of the result path, which converts binary products to BCD for the 7-segment displays.

## Interface
Parameters:
- W_DATA, 16, operand width in bits (data_t)
- W_BCD, 4, digit width in bits (bcd_t)
- MAX_DIGITS, 5, maximum digits per operand

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous abort; clears all state to the post-reset state
- digit_i  in  W_BCD  BCD digit, most significant digit first
- digit_valid_i  in  1  digit_i is valid
- digit_ready_o  out  1  loader accepts digits
- enter_i  in  1  one-cycle pulse that commits the operand currently being loaded
- op_x_o  out  W_DATA  committed operand X
- op_y_o  out  W_DATA  committed operand Y
- operands_valid_o  out  1  X/Y pair is available
- operands_ack_i  in  1  consumer takes the pair
- stage_o  out  1  operand being loaded: 0 = X, 1 = Y
- digit_count_o  out  3  digits accepted into the current operand
- overflow_o  out  1  sticky flag: current transaction overflowed
- bad_digit_o  out  1  one-cycle pulse: a non-BCD digit was received

## Operation
- States: LOAD_X, LOAD_Y, HOLD. Reset and clear_i both go to LOAD_X.
- digit_ready_o is 1 in LOAD_X and LOAD_Y, and 0 in HOLD. A digit is accepted when digit_valid_i and digit_ready_o are both 1.
- Accumulation uses an internal acc register.
  - acc_next = acc*10 + digit, computed in W_DATA+4 bits as (acc<<3)+(acc<<1)+digit.
  - An accepted digit updates acc and increments the count only if all of the following hold:
    - digit ≤ 9
    - digit_count < MAX_DIGITS
    - acc_next ≤ 2^W_DATA−1
- Digit > 9: the digit is discarded, bad_digit_o pulses for 1 cycle, and acc and count are unchanged.
- Digit count already at MAX_DIGITS, or acc_next > 0xFFFF: the digit is discarded, overflow_o is set, and acc keeps its last valid value.
- enter_i in LOAD_X: op_x_o ← acc, acc ← 0, count ← 0, next state LOAD_Y.
- enter_i in LOAD_Y: op_y_o ← acc, acc ← 0, count ← 0, next state HOLD, operands_valid_o ← 1.
- enter_i with zero digits entered commits 0.
- Digit and enter_i in the same cycle: the digit is processed first. The committed value is the updated acc when the digit is legal; otherwise it is the unchanged acc, and the overflow or bad-digit flags still apply.
- enter_i in HOLD is ignored.
- HOLD: operands_valid_o stays 1 and op_x_o/op_y_o stay stable until operands_ack_i. On ack, the next state is LOAD_X, and operands_valid_o and overflow_o clear.
- operands_ack_i outside HOLD is ignored.
- clear_i has priority over all other inputs in any state. It clears acc, count, both op registers, operands_valid_o and overflow_o, and moves to LOAD_X.

## Timing
- All outputs are registered except digit_ready_o, which is decoded from the state register.
- Reset values of all outputs are 0, except digit_ready_o = 1 (state LOAD_X).
- Throughput: one digit per cycle. digit_count_o reflects an accepted digit on the next cycle.
- op_x_o updates 1 cycle after the enter_i that commits X.
- op_y_o and operands_valid_o update 1 cycle after the enter_i that commits Y. Latency from Y commit to valid is 1 cycle.
- operands_valid_o falls 1 cycle after the ack cycle. digit_ready_o is 1 in that same cycle.
- bad_digit_o is high for exactly the cycle after the bad digit was sampled.
- overflow_o rises the cycle after the offending digit.
- Asserting rst_n mid-operation returns the block to the reset state immediately (asynchronous reset).

## Test plan
- Basic load: digits 1,2,3, enter, then 4,5, enter → op_x_o = 0x007B and op_y_o = 0x002D. operands_valid_o rises 1 cycle after the second enter and holds through a 10-cycle ack delay; ack → valid = 0 and stage_o = 0.
- Range limit, no overflow: digits 6,5,5,3,5 → 0xFFFF with overflow_o = 0.
- Range limit, overflow: digits 6,5,5,3,6 → overflow_o = 1 after the fifth digit, and the committed value is 0x1999 (6553).
- Digit count limit: digits 0,0,0,0,0,7 → the sixth digit is discarded, overflow_o = 1, committed value 0. overflow_o clears on ack.
- Bad digit and same-cycle commit:
  - digit 0xA → bad_digit_o pulses for 1 cycle, digit_count_o unchanged.
  - digits 4 then 2, with enter_i in the same cycle as the 2 → op_x_o = 42.
- Abort and backpressure:
  - In HOLD, digit_valid_i = 1 → not accepted (ready = 0).
  - clear_i mid-LOAD_Y → all outputs 0, state LOAD_X.
  - rst_n low during HOLD → operands_valid_o = 0 immediately.
